// File: rtl/bias_accum_relu_pkg.sv
// Shared widths and the saturate/ReLU helper for the bias accumulator.
// Lane packing: lane i occupies [w*(i+1)-1 : w*i] of a packed vector.
package bias_accum_relu_pkg;

  localparam int N_LANE_DEF = 16;
  localparam int DATA_W_DEF = 18;
  localparam int ACC_W_DEF  = 24;
  localparam int SAT_W      = 64;

  typedef logic signed [SAT_W-1:0] wide_t;

  function automatic int lane_lo(int lane, int w);
    return lane * w;
  endfunction

  // Clamp to a dw-bit signed range, then optionally zero negatives.
  function automatic wide_t sat_relu(
    wide_t s,
    int    dw,
    logic  relu
  );
    wide_t hi;
    wide_t lo;
    wide_t r;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (s > hi)
      r = hi;
    else if (s < lo)
      r = lo;
    else
      r = s;
    if (relu && (r < 0))
      r = '0;
    return r;
  endfunction

endpackage

// File: rtl/bias_accum_relu_if.sv
// Partial-sum input stream and result output stream.
// slave = accumulator side, master = producer/consumer side.
interface bias_accum_relu_if
  import bias_accum_relu_pkg::*;
#(
  parameter int N      = N_LANE_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [N*DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N*DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/bias_accum_lane.sv
// One lane: bias-seeded accumulator and the registered sat/ReLU result.
// Control strobes come from the top; this lane holds data state only.
module bias_accum_lane
  import bias_accum_relu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     first,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  localparam int EXT = ACC_W - DATA_W;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;

  // Pass 0 starts from the bias instead of the stale accumulator.
  assign base = first ? {{EXT{bias[DATA_W-1]}}, bias} : acc;
  assign sum  = base + {{EXT{din[DATA_W-1]}}, din};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (en)
        acc <= sum;
      if (load)
        dout <= DATA_W'(sat_relu(SAT_W'(sum), DATA_W, RELU_EN));
    end
  end

endmodule

// File: rtl/bias_accum_relu.sv
// Multi-pass lane-parallel bias accumulator with saturation and ReLU.
// Emits one result vector per N_PASS accepted partial-sum vectors.
module bias_accum_relu
  import bias_accum_relu_pkg::*;
#(
  parameter int N_adder_tree = N_LANE_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter int N_PASS       = 3,
  parameter bit RELU_EN      = 1'b1,
  localparam int PC_W        = (N_PASS > 1) ? $clog2(N_PASS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_adder_tree*DATA_W-1:0] bias,
  bias_accum_relu_if.slave               io,
  output logic [PC_W-1:0]                pass_cnt
);

  logic last;
  logic first;
  logic fire;
  logic load;
  logic out_v;

  assign last  = (pass_cnt == PC_W'(N_PASS - 1));
  assign first = (pass_cnt == '0);

  // Only the final pass needs a free (or draining) output register.
  assign io.in_ready  = !last || !out_v || io.out_ready;
  assign fire         = io.in_valid && io.in_ready;
  assign load         = fire && last;
  assign io.out_valid = out_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= '0;
      out_v    <= 1'b0;
    end else begin
      if (fire)
        pass_cnt <= last ? '0 : pass_cnt + PC_W'(1);
      if (load)
        out_v <= 1'b1;
      else if (io.out_ready)
        out_v <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_accum_lane #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .RELU_EN (RELU_EN)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (fire),
      .first (first),
      .load  (load),
      .bias  (bias[lane_lo(i, DATA_W) +: DATA_W]),
      .din   (io.in_data[lane_lo(i, DATA_W) +: DATA_W]),
      .dout  (io.out_data[lane_lo(i, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_bias_accum_relu.sv
// Directed bench: three builds (ReLU on, ReLU off, single pass)
// checked against a bench-side model through result queues.
module tb_bias_accum_relu;

  localparam int N  = 16;
  localparam int DW = 18;

  typedef logic [N*DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t bias = '0;
  logic [1:0] pc0;
  logic [1:0] pc1;
  logic [0:0] pc2;

  int checks = 0;
  int errors = 0;

  vec_t q0[$];
  vec_t q1[$];
  vec_t q2[$];

  longint macc[3][N];
  int     mpass[3] = '{0, 0, 0};
  int     npass[3] = '{3, 3, 1};
  bit     relu[3]  = '{1'b1, 1'b0, 1'b1};
  vec_t   last_exp[3];

  always #5 clk = ~clk;

  bias_accum_relu_if #(.N(N), .DATA_W(DW)) b0 ();
  bias_accum_relu_if #(.N(N), .DATA_W(DW)) b1 ();
  bias_accum_relu_if #(.N(N), .DATA_W(DW)) b2 ();

  bias_accum_relu #(
    .N_adder_tree(N), .DATA_W(DW), .ACC_W(24),
    .N_PASS(3), .RELU_EN(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .bias(bias),
    .io(b0.slave), .pass_cnt(pc0)
  );

  bias_accum_relu #(
    .N_adder_tree(N), .DATA_W(DW), .ACC_W(24),
    .N_PASS(3), .RELU_EN(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .bias(bias),
    .io(b1.slave), .pass_cnt(pc1)
  );

  bias_accum_relu #(
    .N_adder_tree(N), .DATA_W(DW), .ACC_W(24),
    .N_PASS(1), .RELU_EN(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .bias(bias),
    .io(b2.slave), .pass_cnt(pc2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkv(string tag, vec_t obs, vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rep(int v);
    vec_t r;
    for (int i = 0; i < N; i++)
      r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic vec_t mkv(int a0, int a15, int k);
    vec_t r;
    for (int i = 0; i < N; i++)
      r[i*DW +: DW] = DW'(i * k - 40);
    r[0 +: DW]       = DW'(a0);
    r[15*DW +: DW]   = DW'(a15);
    return r;
  endfunction

  function automatic logic [31:0] lane(vec_t v, int i);
    logic [DW-1:0] s;
    s = v[i*DW +: DW];
    return 32'(s);
  endfunction

  task automatic push(int d, vec_t r);
    last_exp[d] = r;
    case (d)
      0:       q0.push_back(r);
      1:       q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  task automatic model_accept(int d, vec_t x);
    vec_t   r;
    longint s;
    for (int i = 0; i < N; i++) begin
      if (mpass[d] == 0)
        s = longint'($signed(bias[i*DW +: DW]));
      else
        s = macc[d][i];
      s = s + longint'($signed(x[i*DW +: DW]));
      macc[d][i] = s;
      if (s > 131071)
        s = 131071;
      else if (s < -131072)
        s = -131072;
      if (relu[d] && s < 0)
        s = 0;
      r[i*DW +: DW] = s[DW-1:0];
    end
    if (mpass[d] == npass[d] - 1) begin
      mpass[d] = 0;
      push(d, r);
    end else begin
      mpass[d]++;
    end
  endtask

  task automatic drive(int d, logic v, vec_t x);
    case (d)
      0:       begin b0.in_valid = v; b0.in_data = x; end
      1:       begin b1.in_valid = v; b1.in_data = x; end
      default: begin b2.in_valid = v; b2.in_data = x; end
    endcase
  endtask

  function automatic logic rdy(int d);
    case (d)
      0:       return b0.in_ready;
      1:       return b1.in_ready;
      default: return b2.in_ready;
    endcase
  endfunction

  // Holds valid until accepted; returns at posedge+1 after the accept.
  task automatic send(int d, vec_t x);
    bit ok;
    ok = 1'b0;
    drive(d, 1'b1, x);
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (rdy(d)) begin
        model_accept(d, x);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    drive(d, 1'b0, x);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send%0d: in_ready low for 40 cycles", d);
    end
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (!rst && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0: unexpected output %h", b0.out_data);
      end else begin
        e = q0.pop_front();
        chkv("sb0", b0.out_data, e);
      end
    end
  end

  always @(negedge clk) begin
    vec_t e;
    if (!rst && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1: unexpected output %h", b1.out_data);
      end else begin
        e = q1.pop_front();
        chkv("sb1", b1.out_data, e);
      end
    end
  end

  always @(negedge clk) begin
    vec_t e;
    if (!rst && b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb2: unexpected output %h", b2.out_data);
      end else begin
        e = q2.pop_front();
        chkv("sb2", b2.out_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a_exp;
    vec_t x;
    drive(0, 1'b1, rep(77));
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    b2.out_ready = 1'b1;

    // reset with valid held high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(b0.in_ready), 1);
    chk("rst_out_valid", 32'(b0.out_valid), 0);
    chkv("rst_out_data", b0.out_data, '0);
    chk("rst_pass_cnt", 32'(pc0), 0);
    rst = 1'b0;
    drive(0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk("idle_pass_cnt", 32'(pc0), 0);

    // basic three-pass with bias and ReLU
    bias = mkv(100, -7, 2);
    send(0, mkv(10, 1, 1));
    chk("basic_pc1", 32'(pc0), 1);
    send(0, mkv(20, 1, 3));
    send(0, mkv(30, 1, -2));
    chk("basic_valid", 32'(b0.out_valid), 1);
    chk("basic_lane0", lane(b0.out_data, 0), 160);
    chk("basic_lane15", lane(b0.out_data, 15), 0);

    // positive saturation
    bias = rep(131071);
    repeat (3) send(0, rep(131071));
    chk("sat_pos", lane(b0.out_data, 7), 32'h1FFFF);

    // backpressure on the final pass
    bias = mkv(3, -3, 1);
    send(0, mkv(1, 2, 1));
    send(0, mkv(4, 5, 2));
    send(0, mkv(7, 8, 3));
    chk("bp_valid_a", 32'(b0.out_valid), 1);
    b0.out_ready = 1'b0;
    a_exp = last_exp[0];
    send(0, mkv(11, 12, -1));
    send(0, mkv(13, 14, 4));
    chk("bp_pc2", 32'(pc0), 2);
    chkv("bp_hold0", b0.out_data, a_exp);
    drive(0, 1'b1, mkv(15, 16, -3));
    @(negedge clk);
    chk("bp_ready_lo0", 32'(b0.in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_lo1", 32'(b0.in_ready), 0);
    chk("bp_valid_hold", 32'(b0.out_valid), 1);
    chkv("bp_hold1", b0.out_data, a_exp);
    @(posedge clk);
    #1;
    b0.out_ready = 1'b1;
    send(0, mkv(15, 16, -3));
    chk("bp_valid_b", 32'(b0.out_valid), 1);
    chkv("bp_data_b", b0.out_data, last_exp[0]);
    a_exp = last_exp[0];
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(b0.out_valid), 0);
    chkv("drain_hold", b0.out_data, a_exp);

    // reset mid-accumulation
    bias = rep(0);
    send(0, rep(9));
    send(0, rep(9));
    chk("mid_pc2", 32'(pc0), 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mpass[0] = 0;
    chk("mid_rst_pc", 32'(pc0), 0);
    chk("mid_rst_valid", 32'(b0.out_valid), 0);
    repeat (3) send(0, rep(5));
    chk("mid_lane0", lane(b0.out_data, 0), 15);
    chk("mid_lane9", lane(b0.out_data, 9), 15);

    // ReLU disabled: negative saturation and negative passthrough
    bias = rep(-131072);
    repeat (3) send(1, rep(-131072));
    chk("sat_neg", lane(b1.out_data, 3), 32'h20000);
    bias = rep(-5);
    repeat (3) send(1, rep(-1));
    chk("neg_pass", lane(b1.out_data, 0), 32'h3FFF8);

    // single-pass build streaming every cycle
    bias = mkv(7, -100, 5);
    for (int k = 0; k < 6; k++) begin
      x = mkv(k * 3, -k, k);
      drive(2, 1'b1, x);
      @(negedge clk);
      chk("p1_ready", 32'(b2.in_ready), 1);
      if (k > 0)
        chk("p1_valid", 32'(b2.out_valid), 1);
      model_accept(2, x);
      @(posedge clk);
      #1;
    end
    drive(2, 1'b0, '0);
    chk("p1_lane0", lane(b2.out_data, 0), 22);
    chk("p1_lane15", lane(b2.out_data, 15), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);
    chk("q2_empty", 32'(q2.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
